// File: rtl/rrf_tag_allocator_pkg.sv
// Shared sizing for the rename register file tag allocator.
// RRF_NUM must stay a power of two so tag arithmetic wraps by truncation.
package rrf_tag_allocator_pkg;

  localparam int RRF_NUM    = 64;
  localparam int RRF_SEL    = 6;
  localparam int RRF_FREE_W = RRF_SEL + 1;

  typedef logic [RRF_SEL-1:0]    rrf_tag_t;
  typedef logic [RRF_FREE_W-1:0] rrf_cnt_t;

  // Tag addition around the circular buffer; relies on RRF_NUM being 2**RRF_SEL.
  function automatic rrf_tag_t tag_add(input rrf_tag_t a, input rrf_tag_t b);
    return a + b;
  endfunction

endpackage

// File: rtl/rrf_tag_allocator.sv
// RRF tag allocator: hands out up to two tags per cycle to dispatch, reclaims
// up to two per cycle at in-order commit, and rolls back on a mispredict.
// Grants are combinational on registered state; all state moves on the clk edge.
module rrf_tag_allocator
  import rrf_tag_allocator_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               dpreq1,
  input  logic               dpreq2,
  output logic [RRF_SEL-1:0] dptag1,
  output logic [RRF_SEL-1:0] dptag2,
  output logic               dpen1,
  output logic               dpen2,
  output logic               stall,
  input  logic               com1en,
  input  logic               com2en,
  output logic [RRF_SEL-1:0] com1tag,
  output logic [RRF_SEL-1:0] com2tag,
  input  logic               prmiss,
  input  logic [RRF_SEL-1:0] prmiss_tag,
  output logic [RRF_SEL:0]   freenum,
  output logic [RRF_SEL-1:0] alloc_ptr_o
);

  rrf_tag_t alloc_ptr;
  rrf_tag_t com_ptr;
  rrf_cnt_t free_cnt;

  logic [1:0] reqnum;
  logic [1:0] comnum;
  logic [1:0] allocnum;
  logic       fire;
  rrf_tag_t   com_ptr_next;
  rrf_tag_t   miss_dist;   // branch distance from the post-commit head
  rrf_tag_t   miss_age;    // branch distance from the current head
  rrf_cnt_t   live_cnt;

  // Grant decision and tag selection from registered pointers only; tags
  // released by this cycle's commit are not visible until next cycle.
  always_comb begin
    reqnum       = {1'b0, dpreq1} + {1'b0, dpreq2};
    comnum       = {1'b0, com1en} + {1'b0, com2en};
    stall        = (rrf_cnt_t'(reqnum) > free_cnt) | prmiss;
    fire         = (reqnum != 2'd0) & ~stall;
    dpen1        = dpreq1 & fire;
    dpen2        = dpreq2 & fire;
    allocnum     = {1'b0, dpen1} + {1'b0, dpen2};
    dptag1       = alloc_ptr;
    dptag2       = tag_add(alloc_ptr, rrf_tag_t'(dpreq1));
    com1tag      = com_ptr;
    com2tag      = tag_add(com_ptr, rrf_tag_t'(1));
    com_ptr_next = tag_add(com_ptr, rrf_tag_t'(comnum));
    miss_dist    = prmiss_tag - com_ptr_next;
    miss_age     = prmiss_tag - com_ptr;
    live_cnt     = rrf_cnt_t'(RRF_NUM) - free_cnt;
    freenum      = free_cnt;
    alloc_ptr_o  = alloc_ptr;
  end

  // Pointer and free-count update; a mispredict truncates the buffer just
  // past the branch, while same-cycle commits still advance the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_ptr <= '0;
      com_ptr   <= '0;
      free_cnt  <= rrf_cnt_t'(RRF_NUM);
    end else begin
      com_ptr <= com_ptr_next;
      if (prmiss) begin
        alloc_ptr <= tag_add(prmiss_tag, rrf_tag_t'(1));
        free_cnt  <= rrf_cnt_t'(RRF_NUM - 1) - rrf_cnt_t'(miss_dist);
      end else begin
        alloc_ptr <= tag_add(alloc_ptr, rrf_tag_t'(allocnum));
        free_cnt  <= free_cnt - rrf_cnt_t'(allocnum) + rrf_cnt_t'(comnum);
      end
    end
  end

  // Commits are in order: the second slot only retires alongside the first.
  a_com_order : assert property (@(posedge clk) disable iff (reset)
    com2en |-> com1en);

  // Cannot retire more entries than are live.
  a_com_live : assert property (@(posedge clk) disable iff (reset)
    rrf_cnt_t'(comnum) <= live_cnt);

  // A mispredicted branch must be live and must survive this cycle's commits.
  a_miss_live : assert property (@(posedge clk) disable iff (reset)
    prmiss |-> ((rrf_cnt_t'(miss_age) < live_cnt) && (miss_age >= rrf_tag_t'(comnum))));

endmodule

// File: doc/rrf_tag_allocator.md
Name: rrf_tag_allocator

Overview:
- Allocation and commit-side manager for the rename register file (RRF).
- Hands out up to two free RRF tags per cycle to dispatch, which drives the RRF's dispatch-clear enables and addresses. Reclaims up to two tags per cycle at in-order commit, and supplies the commit read tags to the RRF.
- Tags form a circular buffer: allocation pointer `alloc_ptr`, commit pointer `com_ptr`, and a free-entry counter.
- Supports single-cycle rollback on branch misprediction.

Parameters:
- RRF_NUM, 64, number of RRF entries; must be a power of two.
- RRF_SEL, 6, tag width; equals log2(RRF_NUM).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dpreq1  in  1  dispatch slot 1 requests a tag.
- dpreq2  in  1  dispatch slot 2 requests a tag.
- dptag1  out  RRF_SEL  tag for slot 1.
- dptag2  out  RRF_SEL  tag for slot 2.
- dpen1  out  1  slot-1 allocation fires this cycle; drives the RRF dispatch enable.
- dpen2  out  1  slot-2 allocation fires this cycle.
- stall  out  1  requests cannot be satisfied this cycle.
- com1en  in  1  oldest entry commits.
- com2en  in  1  second-oldest entry commits.
- com1tag  out  RRF_SEL  tag of oldest live entry (= com_ptr).
- com2tag  out  RRF_SEL  com_ptr+1 mod RRF_NUM.
- prmiss  in  1  branch mispredict; squash all entries younger than prmiss_tag.
- prmiss_tag  in  RRF_SEL  RRF tag of the mispredicted branch.
- freenum  out  RRF_SEL+1  current free-entry count, 0..RRF_NUM.
- alloc_ptr_o  out  RRF_SEL  next tag to allocate (debug/ROB).

Behaviour:
- Reset (synchronous, active-high):
  - alloc_ptr=0, com_ptr=0, freenum=RRF_NUM.
  - Outputs the following cycle: dptag1=0, dptag2=dpreq1, stall=0, dpen1=dpen2=0 when no request.
- Request count: reqnum = dpreq1 + dpreq2, range 0..2.
- Stall and fire (combinational from registered state):
  - stall = (reqnum > freenum) | prmiss. A zero request never stalls, except under prmiss.
  - fire = (reqnum != 0) & ~stall.
  - dpen1 = dpreq1 & fire; dpen2 = dpreq2 & fire.
  - Allocation is all-or-nothing: never a partial grant.
- Tags:
  - dptag1 = alloc_ptr.
  - dptag2 = alloc_ptr + dpreq1, mod RRF_NUM. dpreq2 alone takes alloc_ptr.
- Update on a fire cycle: alloc_ptr += allocnum (mod RRF_NUM), where allocnum = dpen1 + dpen2.
- Commit:
  - comnum = com1en + com2en; com_ptr += comnum (mod).
  - com2en without com1en is illegal (assertion).
  - comnum > RRF_NUM - freenum is illegal (assertion).
  - Tags freed by commit become allocatable the next cycle, not the same cycle. stall uses the registered freenum only.
- freenum_next = freenum - allocnum + comnum. It always stays within 0..RRF_NUM, and freenum==0 is the full condition.
- Misprediction (prmiss=1), highest priority over allocation:
  - com_ptr_next = com_ptr + comnum.
  - d = (prmiss_tag - com_ptr_next) mod RRF_NUM.
  - alloc_ptr <= prmiss_tag + 1 (mod); freenum <= RRF_NUM - 1 - d.
  - Commits in the same cycle are honoured.
  - Committing the branch itself in the prmiss cycle is illegal (assertion).
  - prmiss_tag must be live (assertion).
- Wrap-around: all pointer arithmetic is modulo RRF_NUM; tag RRF_NUM-1 is followed by tag 0.
- Simultaneous alloc+commit in the full state (freenum=0): commit proceeds, allocation stalls, next freenum=comnum.
- Reset mid-operation overrides all inputs, including prmiss.
- No internal latency: grants are combinational on registered state; state updates on the clk edge.

Decomposition:
- Shared constants package/header: RRF_NUM, RRF_SEL, and a localparam for the freenum width (RRF_SEL+1).
- Single flat module; no sub-module is warranted. A modulo-add helper function may live in the shared package.

Test Plan:
- Reset, then dpreq1=dpreq2=1 for 3 cycles, no commits:
  - dptag pairs (0,1), (2,3), (4,5).
  - freenum after three cycles = 58.
- Fill to full with paired requests (32 cycles):
  - freenum=0.
  - Next dual request: stall=1, dpen1=dpen2=0.
  - Same cycle com1en=com2en=1: following cycle freenum=2, grant tags (0,1).
- Wrap: with alloc_ptr=63 and com_ptr=10, dual request:
  - dptag1=63, dptag2=0.
  - alloc_ptr becomes 1.
- Single request on slot 2 only, alloc_ptr=7: dptag2=7, dpen2=1, alloc_ptr becomes 8.
- Mispredict with com_ptr=4, alloc_ptr=20, prmiss_tag=9, com1en=1 same cycle:
  - alloc_ptr=10, com_ptr=5, freenum=59.
  - dpen1=dpen2=0 during the prmiss cycle.
- freenum=1, dual request: stall=1, no partial grant. Single request the next cycle: grant, freenum=0.
